// File: rtl/game_pkg.sv
// Shared types and helpers for the round controller: FSM states, two-digit BCD
// score type, saturating BCD increment and the seven-segment decoder.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segments are {g,f,e,d,c,b,a}, active-low; non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Saturates at 99 so a runaway hit stream cannot wrap the score.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == 4'd9 && v.ones == 4'd9) begin
      r = v;
    end else if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_ctrl_debounce.sv
// Start-button conditioner: 2-flop synchronizer, stable-sample counter and a
// one-cycle pulse on each accepted high-to-low change of the button level.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_n_i;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q;
        cnt_q   <= '0;
        press_q <= ~sync_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Round controller: sequences IDLE/PLAY/OVER around the countdown timer, keeps
// the BCD score and session high score, and drives four seven-segment digits.
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       hit,
  input  logic       game_over_signal,
  output logic       timer_rst_n,
  output logic       in_play,
  output logic [6:0] hex_s0,
  output logic [6:0] hex_s1,
  output logic [6:0] hex_h0,
  output logic [6:0] hex_h1
);

  game_state_t state_q;
  bcd2_t       score_q;
  bcd2_t       score_d;
  bcd2_t       high_q;
  logic        timer_rst_n_q;
  logic        in_play_q;
  logic        go_meta_q;
  logic        go_s_q;
  logic        press;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_n_i(start_n),
    .press_o(press)
  );

  // Score after this cycle's hit, so a hit coinciding with game-over still counts.
  always_comb begin
    score_d = score_q;
    if (hit) score_d = bcd_inc(score_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      score_q       <= '0;
      high_q        <= '0;
      timer_rst_n_q <= 1'b0;
      in_play_q     <= 1'b0;
      go_meta_q     <= 1'b0;
      go_s_q        <= 1'b0;
    end else begin
      go_meta_q <= game_over_signal;
      go_s_q    <= go_meta_q;
      case (state_q)
        // A press while the flag still reads high is dropped: the timer reset
        // has not yet propagated through the synchronizer.
        IDLE: begin
          if (press && !go_s_q) begin
            state_q       <= PLAY;
            score_q       <= '0;
            timer_rst_n_q <= 1'b1;
            in_play_q     <= 1'b1;
          end
        end
        PLAY: begin
          score_q <= score_d;
          if (go_s_q) begin
            state_q   <= OVER;
            in_play_q <= 1'b0;
            if ({score_d.tens, score_d.ones} > {high_q.tens, high_q.ones})
              high_q <= score_d;
          end
        end
        OVER: begin
          if (press) begin
            state_q       <= IDLE;
            timer_rst_n_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          timer_rst_n_q <= 1'b0;
          in_play_q     <= 1'b0;
        end
      endcase
    end
  end

  assign timer_rst_n = timer_rst_n_q;
  assign in_play     = in_play_q;
  assign hex_s0      = bcd_to_seg(score_q.ones);
  assign hex_s1      = bcd_to_seg(score_q.tens);
  assign hex_h0      = bcd_to_seg(high_q.ones);
  assign hex_h1      = bcd_to_seg(high_q.tens);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed round scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_game_ctrl;

  localparam int D = 4;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic       clk;
  logic       rst;
  logic       start_n;
  logic       hit;
  logic       game_over_signal;
  logic       timer_rst_n;
  logic       in_play;
  logic [6:0] hex_s0;
  logic [6:0] hex_s1;
  logic [6:0] hex_h0;
  logic [6:0] hex_h1;

  int total = 0;
  int bad   = 0;

  logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  game_ctrl #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_n         (start_n),
    .hit             (hit),
    .game_over_signal(game_over_signal),
    .timer_rst_n     (timer_rst_n),
    .in_play         (in_play),
    .hex_s0          (hex_s0),
    .hex_s1          (hex_s1),
    .hex_h0          (hex_h0),
    .hex_h1          (hex_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: integer score/high, raw-input delay lines for the two
  // synchronizers, and a run length of samples that disagree with the accepted
  // button level. Inputs are stable at the rising edge (driven on falling edges).
  int   mState;
  int   mScore;
  int   mHigh;
  int   mRun;
  logic mAcc;
  logic mPress;
  logic sPipe [2];
  logic gPipe [2];
  bit   modelValid = 1'b0;

  always @(posedge clk) begin
    logic sampleS;
    logic goNow;
    if (!rst) begin
      mState = M_IDLE; mScore = 0; mHigh = 0; mRun = 0;
      mAcc = 1'b1; mPress = 1'b0;
      sPipe[0] = 1'b1; sPipe[1] = 1'b1;
      gPipe[0] = 1'b0; gPipe[1] = 1'b0;
      modelValid = 1'b1;
    end else begin
      sampleS = sPipe[1];
      goNow   = gPipe[1];
      if (mState == M_IDLE) begin
        if (mPress && !goNow) begin
          mState = M_PLAY;
          mScore = 0;
        end
      end else if (mState == M_PLAY) begin
        if (hit && mScore < 99) mScore++;
        if (goNow) begin
          if (mScore > mHigh) mHigh = mScore;
          mState = M_OVER;
        end
      end else begin
        if (mPress) mState = M_IDLE;
      end
      mPress = 1'b0;
      if (sampleS != mAcc) begin
        mRun++;
        if (mRun == D) begin
          mAcc   = sampleS;
          mRun   = 0;
          mPress = !sampleS;
        end
      end else begin
        mRun = 0;
      end
      sPipe[1] = sPipe[0]; sPipe[0] = start_n;
      gPipe[1] = gPipe[0]; gPipe[0] = game_over_signal;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("timer_rst_n", 7'(timer_rst_n), 7'(mState != M_IDLE));
      checkOutput("in_play", 7'(in_play), 7'(mState == M_PLAY));
      checkOutput("hex_s0", hex_s0, segTab[mScore % 10]);
      checkOutput("hex_s1", hex_s1, segTab[mScore / 10]);
      checkOutput("hex_h0", hex_h0, segTab[mHigh % 10]);
      checkOutput("hex_h1", hex_h1, segTab[mHigh / 10]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic h, input logic g, input int cycles);
    rst = r; start_n = s; hit = h; game_over_signal = g;
    tick(cycles);
  endtask

  task automatic pressButton();
    start_n = 1'b0;
    tick(10);
    start_n = 1'b1;
    tick(8);
  endtask

  task automatic hitBurst(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      tick(1);
      hit = 1'b0;
      tick($urandom_range(0, 2));
    end
    hit = 1'b0;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("lit_reset_timer", 7'(timer_rst_n), 7'd0);
    checkOutput("lit_reset_inplay", 7'(in_play), 7'd0);
    checkOutput("lit_reset_s0", hex_s0, 7'h40);
    checkOutput("lit_reset_s1", hex_s1, 7'h40);
    checkOutput("lit_reset_h0", hex_h0, 7'h40);
    checkOutput("lit_reset_h1", hex_h1, 7'h40);
    rst = 1'b1;

    // Glitches of 1 and 3 samples must not start a round.
    for (int i = 0; i < 3; i++) begin
      start_n = 1'b0; tick(1);
      start_n = 1'b1; tick(3);
    end
    start_n = 1'b0; tick(3);
    start_n = 1'b1; tick(8);
    checkOutput("lit_glitch_idle", 7'(in_play), 7'd0);

    pressButton();
    checkOutput("lit_press_play", 7'(in_play), 7'd1);
    checkOutput("lit_press_timer", 7'(timer_rst_n), 7'd1);

    hitBurst(12);
    tick(1);
    checkOutput("lit_score12_s1", hex_s1, 7'h79);
    checkOutput("lit_score12_s0", hex_s0, 7'h24);

    game_over_signal = 1'b1;
    tick(3);
    checkOutput("lit_over_inplay", 7'(in_play), 7'd0);
    checkOutput("lit_over_h1", hex_h1, 7'h79);
    checkOutput("lit_over_h0", hex_h0, 7'h24);

    pressButton();
    checkOutput("lit_over_to_idle", 7'(timer_rst_n), 7'd0);
    game_over_signal = 1'b0;
    tick(4);

    // Reset in the middle of a round clears score and high score.
    pressButton();
    hitBurst(3);
    rst = 1'b0; tick(1); rst = 1'b1;
    checkOutput("lit_midreset_s0", hex_s0, 7'h40);
    checkOutput("lit_midreset_h0", hex_h0, 7'h40);
    checkOutput("lit_midreset_h1", hex_h1, 7'h40);
    checkOutput("lit_midreset_timer", 7'(timer_rst_n), 7'd0);

    // Hit coincident with the first cycle go_s reads high: score 07 -> 08.
    pressButton();
    hitBurst(7);
    tick(2);
    game_over_signal = 1'b1;
    tick(2);
    hit = 1'b1; tick(1); hit = 1'b0;
    tick(2);
    checkOutput("lit_coinc_s0", hex_s0, 7'h00);
    checkOutput("lit_coinc_s1", hex_s1, 7'h40);
    checkOutput("lit_coinc_h0", hex_h0, 7'h00);
    checkOutput("lit_coinc_inplay", 7'(in_play), 7'd0);

    // Saturation at 99.
    pressButton();
    game_over_signal = 1'b0;
    tick(4);
    pressButton();
    hit = 1'b1; tick(112); hit = 1'b0;
    tick(1);
    checkOutput("lit_sat_s0", hex_s0, 7'h10);
    checkOutput("lit_sat_s1", hex_s1, 7'h10);
    game_over_signal = 1'b1;
    tick(3);
    checkOutput("lit_sat_h1", hex_h1, 7'h10);

    // Randomized phase.
    begin
      int sHold = 0;
      int gHold = 0;
      for (int c = 0; c < 4000; c++) begin
        if (sHold == 0) begin
          start_n = 1'($urandom_range(0, 1));
          sHold   = $urandom_range(1, 12);
        end
        if (gHold == 0) begin
          game_over_signal = ($urandom_range(0, 3) == 0);
          gHold            = $urandom_range(1, 40);
        end
        sHold--;
        gHold--;
        hit = ($urandom_range(0, 2) == 0);
        rst = !($urandom_range(0, 299) == 0);
        tick(1);
      end
      rst = 1'b1; hit = 1'b0;
      tick(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Round controller that sits directly downstream of the countdown timer. It consumes the timer's game-over flag and drives the timer's active-low reset to start, hold and restart rounds. It counts player hits as a two-digit BCD score, keeps a session high score, and drives four seven-segment digits. A debounced start/restart push button sequences rounds.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to accept a button level (10 ms at 50 MHz).
- `clk`  in  1  system clock; the same clock that feeds the timer's clock divider.
- `rst`  in  1  synchronous reset, active-low.
- `start_n`  in  1  raw push button, active-low, asynchronous to `clk`.
- `hit`  in  1  single-cycle hit pulse from game logic, `clk` domain.
- `game_over_signal`  in  1  timer's game-over flag; generated on the divided clock, so it is treated as asynchronous.
- `timer_rst_n`  out  1  drives the timer's `rst`; low holds the timer at 60.
- `in_play`  out  1  high while in PLAY.
- `hex_s0`, `hex_s1`  out  7  score ones and tens digits.
- `hex_h0`, `hex_h1`  out  7  high-score ones and tens digits.

## Operation
- Segment encoding is {g,f,e,d,c,b,a}, active-low. Digits 0–9 use standard patterns.
- `game_over_signal` passes through a 2-flop synchronizer; the result is `go_s`.
- `start_n` passes through a 2-flop synchronizer and then a debouncer.
  - The accepted level changes only after `DEBOUNCE_CYCLES` consecutive identical samples.
  - The debouncer emits `press`, a 1-cycle pulse, on each accepted high→low change.
  - Exactly one `press` is produced per physical press.
- Score and high score are each two BCD digits, range 00–99.
  - Increment: ones digit 9 wraps to 0 and carries into tens.
  - At 99 the score saturates; further hits are ignored.
- FSM states: IDLE, PLAY, OVER.
  - IDLE: `timer_rst_n`=0. `press` with `go_s`=0 → PLAY and score←00. `press` with `go_s`=1 is ignored, because the synchronizer is not yet flushed.
  - PLAY: `timer_rst_n`=1, `in_play`=1. `hit` increments the score. `go_s`=1 → OVER. `press` is ignored.
  - OVER: `timer_rst_n`=1, so the timer stays at 00 with its flag high. `press` → IDLE. The score stays displayed until the next PLAY entry.
- High-score update happens on the PLAY→OVER transition: high ← max(high, final score). The final score includes any hit taken in the transition cycle.
- `hit` outside PLAY is ignored.

## Timing
- Reset values (rst=0 at a `clk` edge): state IDLE, score 00, high 00, `timer_rst_n`=0, `in_play`=0, debouncer accepted level high, counter 0, synchronizers 1 (start) and 0 (game over).
- All outputs are registered or decoded combinationally from registers. Hex outputs reflect register state in the same cycle.
- `hit` at edge N: the score value is visible after edge N.
- `press` latency: the raw low level must pass 2 synchronizer cycles plus `DEBOUNCE_CYCLES` stable samples. `press` is high for the following cycle. The state changes at the edge after that.
- `go_s` lags the raw flag by 2 edges. PLAY→OVER occurs at the edge where `go_s` is first sampled high.
- Simultaneous `hit` and `go_s` in PLAY: the hit is counted, the state moves to OVER, and the high score compares against the incremented value.
- `timer_rst_n` is a registered output and is glitch-free. IDLE drives it low for at least 1 cycle, so the timer is always reset between rounds.
- Reset asserted mid-round: all state clears at that edge, and `timer_rst_n` drops low in the same cycle.

## Structure
- Package `game_pkg`:
  - state enum `game_state_t` {IDLE, PLAY, OVER};
  - `SEG_BLANK`=7'h7F;
  - BCD-to-segment function `bcd_to_seg`;
  - typedef `bcd2_t` (two 4-bit digits).
- Sub-module `debounce`: synchronizer, stable counter and falling-edge pulse, parameterised by `DEBOUNCE_CYCLES`. The top module instantiates it once.
- The top module contains the FSM, the BCD score and high-score registers, the game-over synchronizer and four `bcd_to_seg` decodes.

## Test plan
Use `DEBOUNCE_CYCLES`=4 in simulation.
- Reset held low for 3 cycles → state IDLE, `timer_rst_n`=0, all hex show 0 (7'h40).
- `start_n` low for 10 cycles with 1-cycle glitches beforehand → exactly one transition to PLAY; glitches shorter than 4 samples cause nothing.
- In PLAY, 12 `hit` pulses → score 12 (`hex_s1`=7'h79, `hex_s0`=7'h24); 100 further hits → score saturates at 99.
- `game_over_signal` rises with score 12 and high 00 → OVER 2–3 cycles later, high becomes 12, `in_play`=0.
- `hit` in the same cycle that `go_s` first reads 1, score 07 → score 08, high 08.
- Mid-PLAY reset → score 00, high 00, IDLE; `press` in OVER → IDLE with `timer_rst_n`=0.
